// File: rtl/ysyx_22041211_imem_responder.sv
// Instruction-memory responder: valid/ready fetch slave backed by a byte-maskable word array.
// Latency: r_valid rises exactly LATENCY cycles after the address handshake.
// Backpressure: response held stable until r_ready; one outstanding request, ar_ready only in IDLE.
module ysyx_22041211_imem_responder #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int                    LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ar_valid,
    output logic                  ar_ready,
    input  logic [ADDR_WIDTH-1:0] ar_addr,
    output logic                  r_valid,
    input  logic                  r_ready,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic [1:0]            r_resp,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [3:0]            wr_mask
);

    localparam int                    IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] SPAN  = ADDR_WIDTH'(DEPTH * 4);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state, state_next;
    logic [3:0]            cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  load_resp;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic [ADDR_WIDTH-1:0] cap_off;
    logic [ADDR_WIDTH-1:0] wr_off;

    assign ar_ready = (state == IDLE) && !rst;
    assign r_valid  = (state == RESP);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (ar_valid) state_next = (LATENCY > 1) ? WAIT : RESP;
            WAIT: if (cnt == 4'd1) state_next = RESP;
            RESP: if (r_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // With LATENCY==1 the capture happens on the acceptance edge, so bypass the latch.
    assign load_resp = (state_next == RESP) && (state != RESP);
    assign cap_addr  = (state == IDLE) ? ar_addr : addr_q;
    assign cap_off   = cap_addr - BASE_ADDR;
    assign wr_off    = wr_addr - BASE_ADDR;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            addr_q <= '0;
            r_data <= '0;
            r_resp <= 2'b00;
        end else begin
            state <= state_next;
            if (state == IDLE && ar_valid) begin
                addr_q <= ar_addr;
                cnt    <= 4'(LATENCY - 1);
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            // Misalignment takes priority over range; mem read sees pre-edge contents.
            if (load_resp) begin
                if (cap_addr[1:0] != 2'b00) begin
                    r_resp <= 2'b10;
                    r_data <= '0;
                end else if (cap_off >= SPAN) begin
                    r_resp <= 2'b11;
                    r_data <= '0;
                end else begin
                    r_resp <= 2'b00;
                    r_data <= mem[cap_off[IDX_W+1:2]];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && (wr_off < SPAN)) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_mask[i]) mem[wr_off[IDX_W+1:2]][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22041211_imem_responder.sv
// Directed bench for the instruction-memory responder at LATENCY=2, DEPTH=1024.
module tb_ysyx_22041211_imem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        ar_valid;
    logic        ar_ready;
    logic [31:0] ar_addr;
    logic        r_valid;
    logic        r_ready;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_mask;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ysyx_22041211_imem_responder #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .DEPTH     (1024),
        .BASE_ADDR (32'h8000_0000),
        .LATENCY   (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ar_valid(ar_valid),
        .ar_ready(ar_ready),
        .ar_addr (ar_addr),
        .r_valid (r_valid),
        .r_ready (r_ready),
        .r_data  (r_data),
        .r_resp  (r_resp),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_mask (wr_mask)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        wr_mask = mask;
        step();
        wr_en = 1'b0;
    endtask

    // Full read: accept, check latency, hold for stall cycles, handshake, check return to IDLE.
    task automatic read_check(input string tag, input logic [31:0] addr,
                              input logic [31:0] exp_d, input logic [1:0] exp_r, input int stall);
        chk({tag, "_ar_ready_idle"}, {31'd0, ar_ready}, 32'd1);
        ar_valid = 1'b1;
        ar_addr  = addr;
        step();
        ar_valid = 1'b0;
        chk({tag, "_r_valid_t1"}, {31'd0, r_valid}, 32'd0);
        step();
        chk({tag, "_r_valid_t2"}, {31'd0, r_valid}, 32'd1);
        chk({tag, "_r_data"}, r_data, exp_d);
        chk({tag, "_r_resp"}, {30'd0, r_resp}, {30'd0, exp_r});
        for (int i = 0; i < stall; i++) begin
            step();
            chk({tag, "_hold_valid"}, {31'd0, r_valid}, 32'd1);
            chk({tag, "_hold_data"}, r_data, exp_d);
            chk({tag, "_hold_resp"}, {30'd0, r_resp}, {30'd0, exp_r});
            chk({tag, "_hold_ar_ready"}, {31'd0, ar_ready}, 32'd0);
        end
        r_ready = 1'b1;
        step();
        r_ready = 1'b0;
        chk({tag, "_r_valid_after"}, {31'd0, r_valid}, 32'd0);
        chk({tag, "_ar_ready_after"}, {31'd0, ar_ready}, 32'd1);
    endtask

    initial begin
        rst      = 1'b1;
        ar_valid = 1'b0;
        ar_addr  = 32'h0;
        r_ready  = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = 32'h0;
        wr_data  = 32'h0;
        wr_mask  = 4'h0;

        step();
        step();
        chk("reset_ar_ready", {31'd0, ar_ready}, 32'd0);
        chk("reset_r_valid", {31'd0, r_valid}, 32'd0);
        chk("reset_r_data", r_data, 32'h0);
        chk("reset_r_resp", {30'd0, r_resp}, 32'd0);
        rst = 1'b0;
        step();
        chk("post_reset_ar_ready", {31'd0, ar_ready}, 32'd1);

        // r_ready with no response pending changes nothing.
        r_ready = 1'b1;
        step();
        r_ready = 1'b0;
        chk("stray_rready_valid", {31'd0, r_valid}, 32'd0);
        chk("stray_rready_ar_ready", {31'd0, ar_ready}, 32'd1);

        preload(32'h8000_0000, 32'h0000_0413, 4'b1111);
        read_check("basic", 32'h8000_0000, 32'h0000_0413, 2'b00, 0);
        read_check("backpressure", 32'h8000_0000, 32'h0000_0413, 2'b00, 5);

        read_check("misaligned", 32'h8000_0002, 32'h0, 2'b10, 0);
        read_check("above_range", 32'h8000_1000, 32'h0, 2'b11, 0);
        read_check("below_base", 32'h7FFF_FFFC, 32'h0, 2'b11, 0);

        preload(32'h8000_0004, 32'hAABB_CCDD, 4'b1111);
        preload(32'h8000_0004, 32'h1122_3344, 4'b0101);
        read_check("byte_mask", 32'h8000_0004, 32'hAA22_CC44, 2'b00, 0);

        // Out-of-range write must not alias onto word 0.
        preload(32'h8000_1000, 32'hDEAD_BEEF, 4'b1111);
        read_check("oor_write", 32'h8000_0000, 32'h0000_0413, 2'b00, 0);

        // Write on the acceptance edge is visible to the capture one edge later.
        preload(32'h8000_0000, 32'h0000_0001, 4'b1111);
        ar_valid = 1'b1;
        ar_addr  = 32'h8000_0000;
        wr_en    = 1'b1;
        wr_addr  = 32'h8000_0000;
        wr_data  = 32'h0000_0002;
        wr_mask  = 4'b1111;
        step();
        ar_valid = 1'b0;
        wr_en    = 1'b0;
        step();
        chk("race_early_valid", {31'd0, r_valid}, 32'd1);
        chk("race_early_data", r_data, 32'h0000_0002);
        r_ready = 1'b1;
        step();
        r_ready = 1'b0;

        // Write on the capture edge is not visible.
        preload(32'h8000_0000, 32'h0000_0001, 4'b1111);
        ar_valid = 1'b1;
        ar_addr  = 32'h8000_0000;
        step();
        ar_valid = 1'b0;
        wr_en    = 1'b1;
        wr_addr  = 32'h8000_0000;
        wr_data  = 32'h0000_0002;
        wr_mask  = 4'b1111;
        step();
        wr_en = 1'b0;
        chk("race_capture_valid", {31'd0, r_valid}, 32'd1);
        chk("race_capture_data", r_data, 32'h0000_0001);
        r_ready = 1'b1;
        step();
        r_ready = 1'b0;
        read_check("race_followup", 32'h8000_0000, 32'h0000_0002, 2'b00, 0);

        // Reset in the middle of a pending read drops the response.
        ar_valid = 1'b1;
        ar_addr  = 32'h8000_0004;
        step();
        ar_valid = 1'b0;
        rst      = 1'b1;
        step();
        chk("midreset_r_valid", {31'd0, r_valid}, 32'd0);
        chk("midreset_ar_ready", {31'd0, ar_ready}, 32'd0);
        rst = 1'b0;
        step();
        chk("midreset_after_valid", {31'd0, r_valid}, 32'd0);
        chk("midreset_after_ar_ready", {31'd0, ar_ready}, 32'd1);
        read_check("after_reset", 32'h8000_0004, 32'hAA22_CC44, 2'b00, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
